mem_dump_reader: RTL and testbench

Readback engine for the RISC-V pipeline's data memory, the read-side counterpart to bench/host preloading of data_mem.
- On a start pulse it requests a core halt and waits for acknowledge.
- It then reads a contiguous range of words through a dedicated read port and streams them out over a valid/ready interface, tagged with address and last flag.
- Sits between the core's data memory and the debug/host side; used for post-run result extraction, e.g. the sorted array.

---
 rtl/mem_dump_pkg.sv | 19 +
 rtl/dump_fifo2.sv | 60 ++++++
 rtl/mem_dump_reader.sv | 176 +++++++++++++++++
 tb/tb_mem_dump_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the data-memory dump reader.
package mem_dump_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 11;

  // Tag address of the checksum beat; sliced to the instance's ADDR_W.
  localparam logic [31:0] CK_ADDR_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/dump_fifo2.sv
// Two-entry shift FIFO; the head entry and its valid bit are flops, so they can drive outputs directly.
module dump_fifo2 #(
  parameter int W = 43
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic         full
);

  logic [W-1:0] e0_r, e1_r;
  logic         v0_r, v1_r;

  // Entry storage: push fills the first free slot, pop shifts entry 1 into the head.
  always_ff @(posedge clock) begin
    if (!reset) begin
      e0_r <= {W{1'b0}};
      e1_r <= {W{1'b0}};
      v0_r <= 1'b0;
      v1_r <= 1'b0;
    end else begin
      case ({push, pop && v0_r})
        2'b10: begin
          if (!v0_r) begin
            e0_r <= push_data;
            v0_r <= 1'b1;
          end else begin
            e1_r <= push_data;
            v1_r <= 1'b1;
          end
        end
        2'b01: begin
          e0_r <= e1_r;
          v0_r <= v1_r;
          v1_r <= 1'b0;
        end
        2'b11: begin
          if (v1_r) begin
            e0_r <= e1_r;
            e1_r <= push_data;
          end else begin
            e0_r <= push_data;
          end
        end
        default: begin
          e0_r <= e0_r;
        end
      endcase
    end
  end

  assign head_data  = e0_r;
  assign head_valid = v0_r;
  assign full       = v1_r;

endmodule

// File: rtl/mem_dump_reader.sv
// Halts the core, reads a word range from data memory and streams it out over valid/ready.
// Optional DUMP_CHECKSUM_EN appends a modulo-2^DATA_W sum beat tagged with an all-ones address.
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  localparam int ENT_W = ADDR_W + 1 + DATA_W;
`ifdef DUMP_CHECKSUM_EN
  localparam state_e ZERO_NEXT = ST_DRAIN;
`else
  localparam state_e ZERO_NEXT = ST_FIN;
`endif

  state_e            state_r, state_next_s;
  logic              busy_r, done_r, halt_req_r, halt_next_s;
  logic [ADDR_W-1:0] addr_r, addr_pend_r;
  logic [CNT_W-1:0]  count_r, issued_r;
  logic              rd_pend_r, last_pend_r;
  logic              issue_s, pop_s, push_s, ck_push_s, drain_done_s;
  logic [ENT_W-1:0]  push_data_s, head_s;
  logic              fifo_valid_s, fifo_full_s;
  logic [1:0]        occ_s;
`ifdef DUMP_CHECKSUM_EN
  logic              ck_sent_r;
  logic [DATA_W-1:0] sum_r;
`endif

  assign pop_s = fifo_valid_s && out_ready;
  assign occ_s = {1'b0, fifo_valid_s} + {1'b0, fifo_full_s} + {1'b0, rd_pend_r};

  // Issue looks at this cycle's pop so a word can be read every cycle with only two slots of buffering.
  assign issue_s  = (state_r == ST_READ) && halt_ack && (issued_r != count_r) &&
                    ((occ_s - {1'b0, pop_s}) < 2'd2);
  assign mem_re   = issue_s;
  assign mem_addr = addr_r;

`ifdef DUMP_CHECKSUM_EN
  assign ck_push_s    = (state_r == ST_DRAIN) && !ck_sent_r && !rd_pend_r && (!fifo_full_s || pop_s);
  assign drain_done_s = ck_sent_r && !rd_pend_r && !fifo_valid_s;
  assign push_data_s  = rd_pend_r ? {addr_pend_r, last_pend_r, mem_rdata}
                                  : {CK_ADDR_ONES[ADDR_W-1:0], 1'b1, sum_r};
`else
  assign ck_push_s    = 1'b0;
  assign drain_done_s = !rd_pend_r && !fifo_valid_s;
  assign push_data_s  = {addr_pend_r, last_pend_r, mem_rdata};
`endif
  assign push_s = rd_pend_r || ck_push_s;

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (word_count != {CNT_W{1'b0}}) state_next_s = ST_HALT;
          else                             state_next_s = ZERO_NEXT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_HALT: begin
        if (halt_ack) state_next_s = ST_READ;
        else          state_next_s = ST_HALT;
      end
      ST_READ: begin
        if (issued_r == count_r) state_next_s = ST_DRAIN;
        else                     state_next_s = ST_READ;
      end
      ST_DRAIN: begin
        if (drain_done_s) state_next_s = ST_FIN;
        else              state_next_s = ST_DRAIN;
      end
      ST_FIN:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
    // A zero-length checksum dump drains without ever halting the core.
    halt_next_s = (state_next_s == ST_HALT) || (state_next_s == ST_READ) ||
                  ((state_next_s == ST_DRAIN) && halt_req_r);
  end

  // State register and registered status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      halt_req_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      busy_r     <= (state_next_s == ST_HALT) || (state_next_s == ST_READ) || (state_next_s == ST_DRAIN);
      done_r     <= (state_next_s == ST_FIN);
      halt_req_r <= halt_next_s;
    end
  end

  // Read address/count tracking and the one-cycle read-return pipeline.
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_r      <= {ADDR_W{1'b0}};
      addr_pend_r <= {ADDR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      issued_r    <= {CNT_W{1'b0}};
      rd_pend_r   <= 1'b0;
      last_pend_r <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_r       <= {DATA_W{1'b0}};
      ck_sent_r   <= 1'b0;
`endif
    end else begin
      rd_pend_r   <= issue_s;
      addr_pend_r <= addr_r;
`ifdef DUMP_CHECKSUM_EN
      last_pend_r <= 1'b0;
`else
      last_pend_r <= issue_s && (issued_r == count_r - CNT_W'(1));
`endif
      if ((state_r == ST_IDLE) && start) begin
        addr_r   <= base_addr;
        count_r  <= word_count;
        issued_r <= {CNT_W{1'b0}};
      end else if (issue_s) begin
        addr_r   <= addr_r + ADDR_W'(1);
        issued_r <= issued_r + CNT_W'(1);
      end
`ifdef DUMP_CHECKSUM_EN
      if ((state_r == ST_IDLE) && start) begin
        sum_r     <= {DATA_W{1'b0}};
        ck_sent_r <= 1'b0;
      end else begin
        if (rd_pend_r) sum_r <= sum_r + mem_rdata;
        if (ck_push_s) ck_sent_r <= 1'b1;
      end
`endif
    end
  end

  dump_fifo2 #(.W(ENT_W)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_s),
    .push_data  (push_data_s),
    .pop        (pop_s),
    .head_data  (head_s),
    .head_valid (fifo_valid_s),
    .full       (fifo_full_s)
  );

  assign {out_addr, out_last, out_data} = head_s;
  assign out_valid = fifo_valid_s;
  assign busy      = busy_r;
  assign done      = done_r;
  assign halt_req  = halt_req_r;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader with a one-cycle-latency memory model and auto halt acknowledge.
module tb_mem_dump_reader;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CW = 11;
`ifdef DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic          clock, reset, start, busy, done, halt_req, halt_ack, mem_re;
  logic [AW-1:0] base_addr, mem_addr, out_addr;
  logic [CW-1:0] word_count;
  logic [DW-1:0] mem_rdata, out_data;
  logic          out_valid, out_ready, out_last;

  logic [DW-1:0] mem [1024];
  logic          ack_dly, ack_block, mon_clear;
  logic [DW-1:0] ev [4];

  int checks, passed;
  int cyc, bcnt, done_cnt, re_cnt, stall_err, stall_cnt, ahead_err, noack_re, ack_cyc;
  logic          halt_seen, valid_seen, held_v, h_last;
  logic [DW-1:0] h_data;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] b_data [16];
  logic [AW-1:0] b_addr [16];
  logic          b_last [16];
  int            b_cyc  [16];

  mem_dump_reader dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .halt_req(halt_req), .halt_ack(halt_ack),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign halt_ack = ack_dly && !ack_block;

  // Memory with one-cycle read latency; core acknowledges halt one cycle after the request.
  always @(posedge clock) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    ack_dly <= halt_req;
  end

  // Observer: records accepted beats and protocol violations away from the active edge.
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (mon_clear) begin
      bcnt <= 0; done_cnt <= 0; re_cnt <= 0; stall_err <= 0; stall_cnt <= 0;
      ahead_err <= 0; noack_re <= 0; ack_cyc <= -1;
      halt_seen <= 1'b0; valid_seen <= 1'b0; held_v <= 1'b0;
    end else begin
      if (out_valid && out_ready && bcnt < 16) begin
        b_data[bcnt] <= out_data;
        b_addr[bcnt] <= out_addr;
        b_last[bcnt] <= out_last;
        b_cyc[bcnt]  <= cyc;
        bcnt         <= bcnt + 1;
      end
      if (held_v && !(out_valid && out_data == h_data && out_addr == h_addr && out_last == h_last))
        stall_err <= stall_err + 1;
      held_v <= out_valid && !out_ready;
      h_data <= out_data;
      h_addr <= out_addr;
      h_last <= out_last;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (mem_re) re_cnt <= re_cnt + 1;
      if ((re_cnt + int'(mem_re)) - (bcnt + int'(out_valid && out_ready)) > 2) ahead_err <= ahead_err + 1;
      if (mem_re && !halt_ack) noack_re <= noack_re + 1;
      if (halt_req) halt_seen <= 1'b1;
      if (out_valid) valid_seen <= 1'b1;
      if (halt_ack && halt_req && ack_cyc < 0) ack_cyc <= cyc;
    end
  end

  task automatic clr;
    mon_clear = 1'b1;
    @(negedge clock);
    #1 mon_clear = 1'b0;
  endtask

  task automatic start_xfer(input logic [AW-1:0] b, input logic [CW-1:0] n);
    @(posedge clock); #1;
    start = 1'b1; base_addr = b; word_count = n;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (done_cnt == 0 && k < limit) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (done_cnt == 0) $display("FAIL done_timeout: done_cnt=%0d want >=1 within %0d cycles", done_cnt, limit);
    else passed++;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, halt_req, mem_re, out_valid, out_last} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {busy, done, halt_req, mem_re, out_valid, out_last});
    else passed++;
    checks++;
    if ({mem_addr, out_addr, out_data} !== 52'd0)
      $display("FAIL reset_data: mem_addr=%0d out_addr=%0d out_data=%0d want 0", mem_addr, out_addr, out_data);
    else passed++;
    reset = 1'b1;
  endtask

  task automatic test_basic;
    clr;
    out_ready = 1'b1;
    start_xfer(10'd0, 11'd4);
    wait_done(60);
    repeat (3) @(negedge clock);
    checks++;
    if (bcnt !== 4 + CK) $display("FAIL basic_count: got %0d want %0d", bcnt, 4 + CK); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({b_addr[i], b_data[i]} !== {AW'(i), ev[i]})
        $display("FAIL basic_beat%0d: got (%0d,%0d) want (%0d,%0d)", i, b_addr[i], b_data[i], i, ev[i]);
      else passed++;
      checks++;
      if (b_last[i] !== (CK == 0 && i == 3))
        $display("FAIL basic_last%0d: got %b want %b", i, b_last[i], (CK == 0 && i == 3));
      else passed++;
    end
    checks++;
    if (b_cyc[3] - b_cyc[0] !== 3) $display("FAIL basic_consecutive: span %0d want 3", b_cyc[3] - b_cyc[0]); else passed++;
    checks++;
    if (b_cyc[0] - ack_cyc !== 3) $display("FAIL basic_latency: got %0d want 3", b_cyc[0] - ack_cyc); else passed++;
    checks++;
    if (done_cnt !== 1) $display("FAIL basic_done_once: got %0d want 1", done_cnt); else passed++;
    checks++;
    if ({halt_req, busy} !== 2'b00) $display("FAIL basic_idle: halt_req,busy=%b want 00", {halt_req, busy}); else passed++;
    checks++;
    if (re_cnt !== 4) $display("FAIL basic_reads: got %0d want 4", re_cnt); else passed++;
`ifdef DUMP_CHECKSUM_EN
    checks++;
    if ({b_addr[4], b_last[4], b_data[4]} !== {10'd1023, 1'b1, 32'd210})
      $display("FAIL basic_checksum: got (%0d,%b,%0d) want (1023,1,210)", b_addr[4], b_last[4], b_data[4]);
    else passed++;
`endif
  endtask

  task automatic test_backpressure;
    logic [3:0] pat;
    pat = 4'b1001;
    clr;
    out_ready = 1'b1;
    start_xfer(10'd0, 11'd4);
    for (int k = 0; k < 200; k++) begin
      @(posedge clock); #1;
      out_ready = pat[k % 4];
      if (done_cnt != 0) break;
    end
    out_ready = 1'b1;
    checks++;
    if (done_cnt == 0) $display("FAIL bp_timeout: done_cnt=%0d want >=1", done_cnt); else passed++;
    repeat (3) @(negedge clock);
    checks++;
    if (bcnt !== 4 + CK) $display("FAIL bp_count: got %0d want %0d", bcnt, 4 + CK); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({b_addr[i], b_data[i]} !== {AW'(i), ev[i]})
        $display("FAIL bp_beat%0d: got (%0d,%0d) want (%0d,%0d)", i, b_addr[i], b_data[i], i, ev[i]);
      else passed++;
    end
    checks++;
    if (stall_cnt == 0) $display("FAIL bp_no_stall: stall cycles=%0d want >0", stall_cnt); else passed++;
    checks++;
    if (stall_err !== 0) $display("FAIL bp_stable: unstable stalls=%0d want 0", stall_err); else passed++;
    checks++;
    if (ahead_err !== 0) $display("FAIL bp_outstanding: violations=%0d want 0", ahead_err); else passed++;
    checks++;
    if (done_cnt !== 1) $display("FAIL bp_done_once: got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_wrap;
    logic [AW-1:0] wa [4];
    logic [DW-1:0] wd [4];
    wa = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    wd = '{32'd100, 32'd200, 32'd17, 32'd42};
    clr;
    out_ready = 1'b1;
    start_xfer(10'd1022, 11'd4);
    wait_done(60);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({b_addr[i], b_data[i]} !== {wa[i], wd[i]})
        $display("FAIL wrap_beat%0d: got (%0d,%0d) want (%0d,%0d)", i, b_addr[i], b_data[i], wa[i], wd[i]);
      else passed++;
    end
  endtask

  task automatic test_zero;
    clr;
    start_xfer(10'd5, 11'd0);
`ifdef DUMP_CHECKSUM_EN
    wait_done(12);
    repeat (3) @(negedge clock);
    checks++;
    if (bcnt !== 1) $display("FAIL zero_count: got %0d want 1", bcnt); else passed++;
    checks++;
    if ({b_addr[0], b_last[0], b_data[0]} !== {10'd1023, 1'b1, 32'd0})
      $display("FAIL zero_checksum: got (%0d,%b,%0d) want (1023,1,0)", b_addr[0], b_last[0], b_data[0]);
    else passed++;
`else
    repeat (2) @(negedge clock);
    checks++;
    if (done_cnt !== 1) $display("FAIL zero_done: got %0d want 1 within 2 cycles", done_cnt); else passed++;
    repeat (3) @(negedge clock);
    checks++;
    if (valid_seen !== 1'b0) $display("FAIL zero_valid: got %b want 0", valid_seen); else passed++;
`endif
    checks++;
    if (halt_seen !== 1'b0) $display("FAIL zero_halt: got %b want 0", halt_seen); else passed++;
  endtask

  task automatic test_halt_loss;
    int k;
    clr;
    out_ready = 1'b1;
    start_xfer(10'd0, 11'd4);
    k = 0;
    while (bcnt == 0 && k < 40) begin @(negedge clock); k++; end
    @(posedge clock); #1 ack_block = 1'b1;
    repeat (4) @(posedge clock);
    #1 ack_block = 1'b0;
    wait_done(60);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({b_addr[i], b_data[i]} !== {AW'(i), ev[i]})
        $display("FAIL hl_beat%0d: got (%0d,%0d) want (%0d,%0d)", i, b_addr[i], b_data[i], i, ev[i]);
      else passed++;
    end
    checks++;
    if (noack_re !== 0) $display("FAIL hl_read_without_ack: got %0d want 0", noack_re); else passed++;
    checks++;
    if (re_cnt !== 4) $display("FAIL hl_reads: got %0d want 4", re_cnt); else passed++;
  endtask

  task automatic test_reset_mid;
    int k;
    clr;
    out_ready = 1'b1;
    start_xfer(10'd0, 11'd8);
    k = 0;
    while (bcnt < 2 && k < 40) begin @(negedge clock); k++; end
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({busy, done, halt_req, mem_re, out_valid, out_last} !== 6'b0)
      $display("FAIL mid_reset_ctrl: got %b want 000000", {busy, done, halt_req, mem_re, out_valid, out_last});
    else passed++;
    checks++;
    if ({mem_addr, out_addr, out_data} !== 52'd0)
      $display("FAIL mid_reset_data: mem_addr=%0d out_addr=%0d out_data=%0d want 0", mem_addr, out_addr, out_data);
    else passed++;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (done_cnt !== 0) $display("FAIL mid_no_done: got %0d want 0", done_cnt); else passed++;
    clr;
    start_xfer(10'd0, 11'd4);
    wait_done(60);
    repeat (3) @(negedge clock);
    checks++;
    if (bcnt !== 4 + CK) $display("FAIL mid_restart_count: got %0d want %0d", bcnt, 4 + CK); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({b_addr[i], b_data[i]} !== {AW'(i), ev[i]})
        $display("FAIL mid_beat%0d: got (%0d,%0d) want (%0d,%0d)", i, b_addr[i], b_data[i], i, ev[i]);
      else passed++;
    end
  endtask

  initial begin
    checks = 0; passed = 0; cyc = 0;
    reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    out_ready = 1'b1; ack_block = 1'b0; mon_clear = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 7 + 5);
    mem[0] = 32'd17; mem[1] = 32'd42; mem[2] = 32'd58; mem[3] = 32'd93;
    mem[1022] = 32'd100; mem[1023] = 32'd200;
    ev = '{32'd17, 32'd42, 32'd58, 32'd93};
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_zero;
    test_halt_loss;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
